udp_tx_msg_arbiter: RTL

//  Shares one UDP TX engine between NUM_SRC message producers (apps/NoC endpoints).
//  - Each source offers a udp_info header, then a payload stream.
//  - A round-robin winner is locked for the whole message.
//  - Emits one udp_tx_metadata_flit with a capture timestamp, then the winner's payload.
//  - Sits between the per-app TX queues and the UDP/IP TX formatter.

---
 rtl/udp_tx_msg_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/udp_tx_msg_arbiter.sv
// udp_tx_msg_arbiter
//   Shares one UDP TX engine between NUM_SRC message producers. Each source
//   offers a 112-bit udp_info header and then a payload stream. A round-robin
//   winner is locked for the whole message. The block emits one metadata flit
//   carrying the header and a capture timestamp, then passes the winner's
//   payload straight through.
//
//   Metadata flit layout (MSB first):
//     [DATA_W-1 -: 112]           udp_info {src_ip, dst_ip, src_port, dst_port, data_length}
//     [DATA_W-113 -: TS_W]        timestamp (ts_cnt in the header-accept cycle)
//     [DATA_W-113-TS_W : 0]       padding, all zeros
//   DATA_W must be at least 112 + TS_W.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   src_hdr_val/hdr/rdy per-source header handshake (rdy one-hot or zero)
//   src_data_*          per-source payload stream (val, data, last, padbytes, rdy)
//   dst_meta_*          metadata flit to the TX engine
//   dst_data_*          payload to the TX engine
//   grant_idx           source currently locked (meaningful while busy)
//   busy                a message is in progress
module udp_tx_msg_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 512,
  parameter int PADBYTES_W = 6,
  parameter int TS_W       = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_hdr_val,
  input  logic [NUM_SRC*112-1:0]        src_hdr,
  output logic [NUM_SRC-1:0]            src_hdr_rdy,
  input  logic [NUM_SRC-1:0]            src_data_val,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  input  logic [NUM_SRC-1:0]            src_data_last,
  input  logic [NUM_SRC*PADBYTES_W-1:0] src_data_padbytes,
  output logic [NUM_SRC-1:0]            src_data_rdy,
  output logic                          dst_meta_val,
  output logic [DATA_W-1:0]             dst_meta,
  input  logic                          dst_meta_rdy,
  output logic                          dst_data_val,
  output logic [DATA_W-1:0]             dst_data,
  output logic                          dst_data_last,
  output logic [PADBYTES_W-1:0]         dst_data_padbytes,
  input  logic                          dst_data_rdy,
  output logic [$clog2(NUM_SRC)-1:0]    grant_idx,
  output logic                          busy
);

  localparam int HDR_W   = 112;
  localparam int IDX_W   = $clog2(NUM_SRC);
  localparam int LEN_LSB = DATA_W - HDR_W;
  localparam int TS_MSB  = DATA_W - HDR_W - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_META = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [TS_W-1:0]   ts_cnt;
  logic [DATA_W-1:0] meta_reg;
  logic [DATA_W-1:0] meta_next;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic [HDR_W-1:0]  win_hdr;
  logic              hdr_fire;
  logic              in_data;
  logic              data_fire;
  logic              meta_zero_len;

  // Modulo-NUM_SRC increment that also works when NUM_SRC is not a power of 2.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_SRC - 1)) return '0;
    else return i + IDX_W'(1);
  endfunction

  // Round-robin scan starting at rr_ptr; the first valid candidate wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!win_found && src_hdr_val[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = idx_inc(cand);
    end
  end

  assign win_hdr  = src_hdr[int'(win_idx)*HDR_W +: HDR_W];
  assign hdr_fire = (state == ST_IDLE) && win_found && !rst;

  always_comb begin
    src_hdr_rdy = '0;
    if (hdr_fire) src_hdr_rdy[win_idx] = 1'b1;
  end

  always_comb begin
    meta_next = '0;
    meta_next[DATA_W-1 -: HDR_W] = win_hdr;
    meta_next[TS_MSB -: TS_W]    = ts_cnt;
  end

  assign meta_zero_len = (meta_reg[LEN_LSB +: 16] == 16'd0);

  assign dst_meta_val = (state == ST_META) && !rst;
  assign dst_meta     = meta_reg;

  // Payload path: zero-latency pass-through of the locked source.
  assign in_data           = (state == ST_DATA) && !rst;
  assign dst_data_val      = in_data && src_data_val[grant_idx];
  assign dst_data          = src_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign dst_data_last     = src_data_last[grant_idx];
  assign dst_data_padbytes = src_data_padbytes[int'(grant_idx)*PADBYTES_W +: PADBYTES_W];
  assign data_fire         = dst_data_val && dst_data_rdy;

  always_comb begin
    src_data_rdy = '0;
    if (in_data) src_data_rdy[grant_idx] = dst_data_rdy;
  end

  assign busy = (state != ST_IDLE);

  // Control state: reset aborts any message in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      ts_cnt    <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      case (state)
        ST_IDLE: begin
          if (hdr_fire) begin
            grant_idx <= win_idx;
            state     <= ST_META;
          end
        end
        ST_META: begin
          if (dst_meta_rdy) begin
            if (meta_zero_len) begin
              state  <= ST_IDLE;
              rr_ptr <= idx_inc(grant_idx);
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (data_fire && dst_data_last) begin
            state  <= ST_IDLE;
            rr_ptr <= idx_inc(grant_idx);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Header capture stage: metadata flit held stable until the engine takes it.
  always_ff @(posedge clk) begin
    if (hdr_fire) meta_reg <= meta_next;
  end

endmodule
